vxu_bank_issue_seq: RTL

VXU_BANK_ISSUE_SEQ -- requirements
Module: vxu_bank_issue_seq

---
 rtl/vxu_bank_issue_seq_pkg.sv | 37 +++
 rtl/vxu_bank_issue_wdelay.sv | 35 +++
 rtl/vxu_bank_issue_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/vxu_bank_issue_seq_pkg.sv
// ---------------------------------------------------------------------------
// vxu_bank_issue_seq_pkg
// Shared B8 bank configuration for the bank issue sequencer: bank count,
// field widths used on the command and stripe ports, FSM state encodings and
// the packed write-stripe record carried through the write-delay pipe.
// No ports (package).
// ---------------------------------------------------------------------------
package vxu_bank_issue_seq_pkg;

  localparam int NBANK      = 8;
  localparam int SZ_LGBANK  = $clog2(NBANK);
  localparam int SZ_VLEN    = 8;
  localparam int SZ_BVLEN   = SZ_LGBANK;
  localparam int SZ_BREGLEN = 8;
  localparam int SZ_BOPL    = 2;
  localparam int SZ_BRPORT  = 8;
  localparam int SZ_BWPORT  = 3;
  localparam int SZ_VIU_FN  = 11;
  localparam int SZ_DATA    = 65;

  // Width of the stripe index: one stripe covers NBANK elements.
  localparam int SZ_STRIPE  = SZ_VLEN - SZ_LGBANK;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic                  wen;
    logic                  wlast;
    logic [SZ_BVLEN-1:0]   wcnt;
    logic [SZ_BREGLEN-1:0] waddr;
  } wstripe_t;

endpackage

// File: rtl/vxu_bank_issue_wdelay.sv
// ---------------------------------------------------------------------------
// vxu_bank_issue_wdelay
// WLAT-deep shift register that delays write-stripe control so each write
// stripe leaves exactly WLAT cycles after the read stripe it belongs to.
// Ports:
//   clk       - clock
//   reset     - asynchronous active-low reset, clears every stage
//   stripe_in - write stripe captured alongside the read stripe
//   stripe_out- write stripe as seen by bank 0
// ---------------------------------------------------------------------------
module vxu_bank_issue_wdelay
  import vxu_bank_issue_seq_pkg::*;
#(
  parameter int WLAT = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  wstripe_t stripe_in,
  output wstripe_t stripe_out
);

  wstripe_t pipe [WLAT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WLAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= stripe_in;
      for (int i = 1; i < WLAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign stripe_out = pipe[WLAT-1];

endmodule

// File: rtl/vxu_bank_issue_seq.sv
// ---------------------------------------------------------------------------
// vxu_bank_issue_seq
// Sequences one vector command into bank 0 as a series of 8-element stripes.
// Each cycle in READ emits one registered read stripe plus its ALU op; the
// matching write stripe is captured at the same time and delayed WLAT cycles
// through vxu_bank_issue_wdelay.
// Ports:
//   clk, reset           - clock, asynchronous active-low reset
//   cmd_val / cmd_rdy    - command handshake (ready only while idle)
//   cmd_*                - command fields, latched on acceptance
//   out_r*               - read-stripe control into bank 0
//   out_w*               - write-stripe control into bank 0
//   out_viu_*            - ALU op issued with each read stripe
//   busy                 - command in flight
// ---------------------------------------------------------------------------
module vxu_bank_issue_seq
  import vxu_bank_issue_seq_pkg::*;
#(
  parameter int WLAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_val,
  output logic                  cmd_rdy,
  input  logic [SZ_VLEN-1:0]    cmd_vlen,
  input  logic [SZ_BREGLEN-1:0] cmd_vs,
  input  logic [SZ_BREGLEN-1:0] cmd_vd,
  input  logic [SZ_BREGLEN-1:0] cmd_stride,
  input  logic [SZ_BOPL-1:0]    cmd_roplen,
  input  logic [SZ_BRPORT-1:0]  cmd_rblen,
  input  logic [SZ_BWPORT-1:0]  cmd_wsel,
  input  logic [SZ_VIU_FN-1:0]  cmd_fn,
  input  logic [SZ_DATA-1:0]    cmd_imm,
  output logic                  out_ren,
  output logic                  out_rlast,
  output logic [SZ_BVLEN-1:0]   out_rcnt,
  output logic [SZ_BREGLEN-1:0] out_raddr,
  output logic [SZ_BOPL-1:0]    out_roplen,
  output logic [SZ_BRPORT-1:0]  out_rblen,
  output logic                  out_wen,
  output logic                  out_wlast,
  output logic [SZ_BVLEN-1:0]   out_wcnt,
  output logic [SZ_BREGLEN-1:0] out_waddr,
  output logic [SZ_BWPORT-1:0]  out_wsel,
  output logic                  out_viu_val,
  output logic [SZ_VIU_FN-1:0]  out_viu_fn,
  output logic [SZ_VLEN-1:0]    out_viu_utidx,
  output logic [SZ_DATA-1:0]    out_viu_imm,
  output logic                  busy
);

  state_t state_q, state_d;

  logic [SZ_VLEN-1:0]    vlen_q;
  logic [SZ_BREGLEN-1:0] stride_q;
  logic [SZ_BOPL-1:0]    roplen_q;
  logic [SZ_BRPORT-1:0]  rblen_q;
  logic [SZ_BWPORT-1:0]  wsel_q;
  logic [SZ_VIU_FN-1:0]  fn_q;
  logic [SZ_DATA-1:0]    imm_q;
  logic [SZ_BREGLEN-1:0] raddr_q;
  logic [SZ_BREGLEN-1:0] waddr_q;
  logic [SZ_STRIPE-1:0]  stripe_q;

  wstripe_t wcand_q;
  wstripe_t wout;

  logic                accept;
  logic                is_last;
  logic [SZ_BVLEN-1:0] rcnt_next;

  assign accept    = (state_q == ST_IDLE) && cmd_val;
  assign is_last   = (stripe_q == vlen_q[SZ_VLEN-1:SZ_LGBANK]);
  // Full stripes cover all banks; the final one covers the low vlen bits.
  assign rcnt_next = is_last ? vlen_q[SZ_LGBANK-1:0] : '1;

  assign cmd_rdy = (state_q == ST_IDLE);
  assign busy    = (state_q != ST_IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: DRAIN ends while the last write stripe is visible, so
  // cmd_rdy rises in the cycle after it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_val)   state_d = ST_READ;
      ST_READ:  if (is_last)   state_d = ST_DRAIN;
      ST_DRAIN: if (wout.wlast) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Command latch, stripe walk and registered read-side outputs. Addresses
  // are accumulated by stride rather than multiplied; wrap is natural.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vlen_q        <= '0;
      stride_q      <= '0;
      roplen_q      <= '0;
      rblen_q       <= '0;
      wsel_q        <= '0;
      fn_q          <= '0;
      imm_q         <= '0;
      raddr_q       <= '0;
      waddr_q       <= '0;
      stripe_q      <= '0;
      wcand_q       <= '0;
      out_ren       <= 1'b0;
      out_rlast     <= 1'b0;
      out_rcnt      <= '0;
      out_raddr     <= '0;
      out_roplen    <= '0;
      out_rblen     <= '0;
      out_viu_val   <= 1'b0;
      out_viu_fn    <= '0;
      out_viu_utidx <= '0;
      out_viu_imm   <= '0;
    end else begin
      wcand_q       <= '0;
      out_ren       <= 1'b0;
      out_rlast     <= 1'b0;
      out_rcnt      <= '0;
      out_raddr     <= '0;
      out_roplen    <= '0;
      out_rblen     <= '0;
      out_viu_val   <= 1'b0;
      out_viu_fn    <= '0;
      out_viu_utidx <= '0;
      out_viu_imm   <= '0;
      if (accept) begin
        vlen_q   <= cmd_vlen;
        stride_q <= cmd_stride;
        roplen_q <= cmd_roplen;
        rblen_q  <= cmd_rblen;
        wsel_q   <= cmd_wsel;
        fn_q     <= cmd_fn;
        imm_q    <= cmd_imm;
        raddr_q  <= cmd_vs;
        waddr_q  <= cmd_vd;
        stripe_q <= '0;
      end
      if (state_q == ST_READ) begin
        out_ren       <= 1'b1;
        out_rlast     <= is_last;
        out_rcnt      <= rcnt_next;
        out_raddr     <= raddr_q;
        out_roplen    <= roplen_q;
        out_rblen     <= rblen_q;
        out_viu_val   <= 1'b1;
        out_viu_fn    <= fn_q;
        out_viu_utidx <= {stripe_q, {SZ_LGBANK{1'b0}}};
        out_viu_imm   <= imm_q;
        wcand_q       <= '{wen: 1'b1, wlast: is_last, wcnt: rcnt_next, waddr: waddr_q};
        raddr_q       <= raddr_q + stride_q;
        waddr_q       <= waddr_q + stride_q;
        stripe_q      <= stripe_q + 1'b1;
      end
    end
  end

  vxu_bank_issue_wdelay #(
    .WLAT(WLAT)
  ) u_wdelay (
    .clk       (clk),
    .reset     (reset),
    .stripe_in (wcand_q),
    .stripe_out(wout)
  );

  assign out_wen   = wout.wen;
  assign out_wlast = wout.wlast;
  assign out_wcnt  = wout.wcnt;
  assign out_waddr = wout.waddr;
  assign out_wsel  = wout.wen ? wsel_q : '0;

endmodule
